// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, data_ram size codes,
// FSM state encoding and request decode helpers.
package load_store_unit_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = FUNCT3_LB;
  localparam logic [2:0] FUNCT3_SH  = FUNCT3_LH;
  localparam logic [2:0] FUNCT3_SW  = FUNCT3_LW;

  localparam logic [2:0] MEM_MODE_WORD = 3'b100;
  localparam logic [2:0] MEM_MODE_HALF = 3'b010;
  localparam logic [2:0] MEM_MODE_BYTE = 3'b001;

  typedef enum logic [1:0] {
    LSU_IDLE    = 2'd0,
    LSU_ISSUE   = 2'd1,
    LSU_CAPTURE = 2'd2,
    LSU_RESP    = 2'd3
  } lsu_state_e;

  function automatic logic [2:0] funct3_mode(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   funct3_mode = MEM_MODE_BYTE;
      2'b01:   funct3_mode = MEM_MODE_HALF;
      default: funct3_mode = MEM_MODE_WORD;
    endcase
  endfunction

  // Unsigned loads have no store counterpart, so 100/101 are illegal with we=1.
  function automatic logic req_legal(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic legal_f3;
    logic aligned;
    case (funct3)
      FUNCT3_LB, FUNCT3_LH, FUNCT3_LW: legal_f3 = 1'b1;
      FUNCT3_LBU, FUNCT3_LHU:          legal_f3 = !we;
      default:                         legal_f3 = 1'b0;
    endcase
    case (funct3[1:0])
      2'b01:   aligned = !addr_lo[0];
      2'b10:   aligned = (addr_lo == 2'b00);
      default: aligned = 1'b1;
    endcase
    req_legal = legal_f3 && aligned;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundles the EX request, WB response and data_ram signals of the load/store unit.
interface load_store_unit_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [RD_W-1:0] req_rd;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic [RD_W-1:0] rsp_rd;
  logic            rsp_err;
  logic            ram_we;
  logic [2:0]      ram_mode;
  logic [XLEN-1:0] ram_address;
  logic [XLEN-1:0] ram_wdata;
  logic [XLEN-1:0] ram_rdata;

  // master: the pipeline/RAM environment around the unit
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, rsp_ready, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
           ram_we, ram_mode, ram_address, ram_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, rsp_ready, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
           ram_we, ram_mode, ram_address, ram_wdata
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Combinational sign/zero extension of right-justified data_ram read data by load funct3.
module lsu_load_extend
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ext
);

  always_comb begin
    case (funct3)
      FUNCT3_LB:  ext = {{(XLEN-8){rdata[7]}}, rdata[7:0]};
      FUNCT3_LBU: ext = {{(XLEN-8){1'b0}}, rdata[7:0]};
      FUNCT3_LH:  ext = {{(XLEN-16){rdata[15]}}, rdata[15:0]};
      FUNCT3_LHU: ext = {{(XLEN-16){1'b0}}, rdata[15:0]};
      default:    ext = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage front end for data_ram: one outstanding load/store, alignment/funct3 checking,
// RAM driving, load extension and a held response towards writeback.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.slave  bus
);

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [2:0]      ram_mode_q, ram_mode_d;
  logic [XLEN-1:0] ram_address_q, ram_address_d;
  logic [XLEN-1:0] ram_wdata_q, ram_wdata_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [RD_W-1:0] rsp_rd_q, rsp_rd_d;
  logic            rsp_err_q, rsp_err_d;
  logic            req_ok;
  logic [XLEN-1:0] load_ext;

  function automatic logic [XLEN-1:0] store_data(input logic [2:0] funct3,
                                                 input logic [XLEN-1:0] wdata);
    case (funct3[1:0])
      2'b00:   store_data = {{(XLEN-8){1'b0}}, wdata[7:0]};
      2'b01:   store_data = {{(XLEN-16){1'b0}}, wdata[15:0]};
      default: store_data = wdata;
    endcase
  endfunction

  assign req_ok = req_legal(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  lsu_load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3 (funct3_q),
    .rdata  (bus.ram_rdata),
    .ext    (load_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE:    if (bus.req_valid) state_d = req_ok ? LSU_ISSUE : LSU_RESP;
      LSU_ISSUE:   state_d = we_q ? LSU_RESP : LSU_CAPTURE;
      LSU_CAPTURE: state_d = LSU_RESP;
      LSU_RESP:    if (bus.rsp_ready) state_d = LSU_IDLE;
      default:     state_d = LSU_IDLE;
    endcase
  end

  // ram_we is gated by rst_n directly so a reset landing mid-ISSUE can never write.
  always_comb begin
    bus.req_ready = (state_q == LSU_IDLE);
    bus.rsp_valid = (state_q == LSU_RESP);
    bus.ram_we    = (state_q == LSU_ISSUE) && we_q && rst_n;
  end

  always_comb begin
    we_d          = we_q;
    funct3_d      = funct3_q;
    ram_mode_d    = ram_mode_q;
    ram_address_d = ram_address_q;
    ram_wdata_d   = ram_wdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_rd_d      = rsp_rd_q;
    rsp_err_d     = rsp_err_q;
    if (state_q == LSU_IDLE && bus.req_valid) begin
      we_d        = bus.req_we;
      funct3_d    = bus.req_funct3;
      rsp_rd_d    = bus.req_rd;
      rsp_err_d   = !req_ok;
      rsp_rdata_d = '0;
      // Erroneous requests leave the RAM driver registers untouched.
      if (req_ok) begin
        ram_address_d = bus.req_addr;
        ram_mode_d    = funct3_mode(bus.req_funct3);
        ram_wdata_d   = store_data(bus.req_funct3, bus.req_wdata);
      end
    end
    if (state_q == LSU_CAPTURE) rsp_rdata_d = load_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q          <= 1'b0;
      funct3_q      <= FUNCT3_LW;
      ram_mode_q    <= MEM_MODE_WORD;
      ram_address_q <= '0;
      ram_wdata_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_rd_q      <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      we_q          <= we_d;
      funct3_q      <= funct3_d;
      ram_mode_q    <= ram_mode_d;
      ram_address_q <= ram_address_d;
      ram_wdata_q   <= ram_wdata_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_rd_q      <= rsp_rd_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign bus.ram_mode    = ram_mode_q;
  assign bus.ram_address = ram_address_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_rd      = rsp_rd_q;
  assign bus.rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random load/store traffic against a byte-array
// data_ram and an independent byte-level reference model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if #(.XLEN(32), .RD_W(5)) bus();

  load_store_unit #(.XLEN(32), .RD_W(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] ram_mem [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  function automatic int mode_bytes(input logic [2:0] mode);
    if (mode == 3'b001) return 1;
    if (mode == 3'b010) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ram_read(input logic [31:0] addr, input logic [2:0] mode);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < mode_bytes(mode); i++)
      v = v | (32'(ram_mem[8'(addr + 32'(i))]) << (8 * i));
    return v;
  endfunction

  // data_ram: byte array, synchronous write, read data registered one cycle after address.
  always @(posedge clk) begin
    if (bus.ram_we) begin
      for (int i = 0; i < 4; i++)
        if (i < mode_bytes(bus.ram_mode))
          ram_mem[8'(bus.ram_address + 32'(i))] <= 8'(bus.ram_wdata >> (8 * i));
    end
    bus.ram_rdata <= ram_read(bus.ram_address, bus.ram_mode);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks();
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_rd", 32'(bus.rsp_rd), 32'd0);
    check("rst_ram_mode", 32'(bus.ram_mode), 32'd4);
    check("rst_ram_address", bus.ram_address, 32'd0);
    check("rst_ram_wdata", bus.ram_wdata, 32'd0);
    check("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  // One complete transaction; the model predicts the result from funct3 rules and ref_mem.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input int stall);
    int size, lat, n, we_cnt, exp_we;
    bit illegal, exp_err;
    longint val;
    logic [31:0] exp_rdata, exp_wd, hold_rdata;
    logic [4:0] hold_rd;

    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && (f3 == 3'd4 || f3 == 3'd5));
    exp_err = illegal || ((addr % size) != 0);
    exp_rdata = '0;
    exp_we = 0;
    val = {32'b0, wdata};
    exp_wd = 32'(val % (64'sd1 <<< (8 * size)));
    if (exp_err) lat = 1;
    else if (we) begin lat = 2; exp_we = 1; end
    else begin
      lat = 3;
      val = 0;
      for (int i = 0; i < size; i++) val = val + (longint'(ref_mem[8'(addr + 32'(i))]) <<< (8 * i));
      if (f3 < 3'd4 && size < 4 && val >= (64'sd1 <<< (8 * size - 1))) val = val - (64'sd1 <<< (8 * size));
      exp_rdata = val[31:0];
    end

    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.rsp_ready  = (stall == 0);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rd     = rd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 1;
    we_cnt = 0;
    while (!bus.rsp_valid && n < 10) begin
      if (bus.ram_we) we_cnt++;
      if (n == 1 && !exp_err) begin
        check("issue_address", bus.ram_address, addr);
        check("issue_mode", 32'(bus.ram_mode), 32'(size));
        if (we) check("issue_wdata", bus.ram_wdata, exp_wd);
      end
      @(negedge clk);
      n++;
    end
    check("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
    check("latency", 32'(n), 32'(lat));
    check("ram_we_pulses", 32'(we_cnt), 32'(exp_we));
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    check("rsp_rdata", bus.rsp_rdata, exp_rdata);
    check("rsp_rd", 32'(bus.rsp_rd), 32'(rd));
    check("req_ready_busy", 32'(bus.req_ready), 32'd0);
    hold_rdata = bus.rsp_rdata;
    hold_rd = bus.rsp_rd;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_rdata", bus.rsp_rdata, hold_rdata);
      check("bp_rsp_rd", 32'(bus.rsp_rd), 32'(hold_rd));
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    if (we && !exp_err)
      for (int i = 0; i < size; i++) ref_mem[8'(addr + 32'(i))] = 8'(wdata >> (8 * i));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_rd = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks();
    rst_n = 1'b1;

    // Word store/load round trip
    do_op(1'b1, 3'b010, 32'h0, 32'hA8A7A6A5, 5'd1, 0);
    do_op(1'b0, 3'b010, 32'h0, 32'h0, 5'd2, 0);
    // Extension variants
    do_op(1'b0, 3'b000, 32'h0, 32'h0, 5'd3, 0);
    do_op(1'b0, 3'b100, 32'h0, 32'h0, 5'd4, 0);
    do_op(1'b0, 3'b001, 32'h0, 32'h0, 5'd5, 0);
    do_op(1'b0, 3'b101, 32'h2, 32'h0, 5'd6, 0);
    // Byte stores into the upper lanes
    do_op(1'b1, 3'b000, 32'h1, 32'h98BADCFE, 5'd7, 0);
    do_op(1'b1, 3'b000, 32'h2, 32'h98BADCFE, 5'd8, 0);
    do_op(1'b1, 3'b000, 32'h3, 32'h98BADCFE, 5'd9, 0);
    do_op(1'b0, 3'b010, 32'h0, 32'h0, 5'd10, 0);
    // Errors: misaligned half/word, illegal funct3, unsigned store
    do_op(1'b0, 3'b001, 32'h1, 32'h0, 5'd11, 0);
    do_op(1'b0, 3'b010, 32'h2, 32'h0, 5'd12, 0);
    do_op(1'b0, 3'b011, 32'h0, 32'h0, 5'd13, 0);
    do_op(1'b1, 3'b100, 32'h0, 32'h55, 5'd14, 0);
    // Top-of-memory word, then backpressured load
    do_op(1'b1, 3'b010, 32'hFFFFFFFC, 32'h13579BDF, 5'd15, 0);
    do_op(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 5'd16, 5);
    do_op(1'b0, 3'b001, 32'h2, 32'h0, 5'd17, 5);

    // Reset landing in ISSUE of a store must suppress the write
    do_op(1'b1, 3'b010, 32'h4, 32'hCAFEF00D, 5'd18, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h4;
    bus.req_wdata = 32'h12345678;
    bus.req_rd = 5'd19;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("issue_we_before_rst", 32'(bus.ram_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ram_we_gated_by_rst", 32'(bus.ram_we), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_checks();
    rst_n = 1'b1;
    do_op(1'b0, 3'b010, 32'h4, 32'h0, 5'd20, 0);

    // Random traffic
    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a = a | 32'hFFFFFFE0;
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
            5'($urandom_range(0, 31)), ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
